// File: rtl/result_bcd_converter.sv
// 16-bit unsigned binary to 5-digit BCD converter (iterative double-dabble).
// A conversion takes 17 cycles from start to the done pulse; bcd/err hold until the next one.
module result_bcd_converter (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [15:0] bin,
   input  logic        div0,
   output logic        busy,
   output logic        done,
   output logic        err,
   output logic [19:0] bcd
);

   localparam int unsigned BIN_W    = 16;
   localparam int unsigned BCD_W    = 20;
   localparam int unsigned DIGITS   = 5;
   localparam int unsigned CNT_W    = 5;
   localparam logic [CNT_W-1:0] LAST_SHIFT = CNT_W'(BIN_W - 1);
   localparam logic [BCD_W-1:0] ERR_CODE   = 20'hEEEEE;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SHIFT  = 2'd1,
      FINISH = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [BCD_W-1:0]   acc_q, acc_d;
   logic [BIN_W-1:0]   bin_q, bin_d;
   logic               div0_q, div0_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic               err_q, err_d;
   logic [BCD_W-1:0]   bcd_q, bcd_d;
   logic [BCD_W-1:0]   adj;
   logic [BCD_W+BIN_W-1:0] shifted;

   // Add 3 to every digit >= 5 so the following left shift carries correctly into the next digit.
   function automatic logic [BCD_W-1:0] add3(input logic [BCD_W-1:0] a);
      logic [BCD_W-1:0] r;
      r = a;
      for (int i = 0; i < DIGITS; i++) begin
         if (a[4*i +: 4] >= 4'd5) begin
            r[4*i +: 4] = a[4*i +: 4] + 4'd3;
         end
      end
      return r;
   endfunction

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         acc_q   <= '0;
         bin_q   <= '0;
         div0_q  <= 1'b0;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         bcd_q   <= '0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         bin_q   <= bin_d;
         div0_q  <= div0_d;
         cnt_q   <= cnt_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         err_q   <= err_d;
         bcd_q   <= bcd_d;
      end
   end

   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      bin_d   = bin_q;
      div0_d  = div0_q;
      cnt_d   = cnt_q;
      done_d  = 1'b0;
      err_d   = err_q;
      bcd_d   = bcd_q;
      adj     = add3(acc_q);
      shifted = {adj, bin_q} << 1;

      case (state_q)
         IDLE: begin
            if (start) begin
               bin_d   = bin;
               div0_d  = div0;
               acc_d   = '0;
               cnt_d   = '0;
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            acc_d = shifted[BCD_W+BIN_W-1:BIN_W];
            bin_d = shifted[BIN_W-1:0];
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == LAST_SHIFT) begin
               state_d = FINISH;
            end
         end
         FINISH: begin
            bcd_d   = div0_q ? ERR_CODE : acc_q;
            err_d   = div0_q;
            done_d  = 1'b1;
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      busy_d = (state_d != IDLE);
   end

   assign busy = busy_q;
   assign done = done_q;
   assign err  = err_q;
   assign bcd  = bcd_q;

endmodule

// File: tb/tb_result_bcd_converter.sv
// Bench for result_bcd_converter: directed scenarios with literal expectations plus
// a long random run compared every cycle against a cycle-count/decimal-arithmetic model.
module tb_result_bcd_converter;

   logic        clk;
   logic        rst;
   logic        start;
   logic [15:0] bin;
   logic        div0;
   logic        busy;
   logic        done;
   logic        err;
   logic [19:0] bcd;

   int checks   = 0;
   int failures = 0;

   result_bcd_converter dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .bin   (bin),
      .div0  (div0),
      .busy  (busy),
      .done  (done),
      .err   (err),
      .bcd   (bcd)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Decimal reference: peel off base-10 digits with plain arithmetic.
   function automatic logic [19:0] to_bcd(input int unsigned v);
      logic [19:0] r;
      int unsigned x;
      r = '0;
      x = v;
      for (int i = 0; i < 5; i++) begin
         r[4*i +: 4] = 4'(x % 10);
         x = x / 10;
      end
      return r;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         if (failures <= 50)
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model: a phase counter 0 (idle) .. 17 plus the captured operands.
   int          m_phase = 0;
   logic        m_valid = 1'b0;
   logic        m_busy  = 1'b0;
   logic        m_done  = 1'b0;
   logic        m_err   = 1'b0;
   logic [19:0] m_bcd   = '0;
   logic [15:0] m_bin   = '0;
   logic        m_div0  = 1'b0;
   int          m_done_cnt = 0;

   always @(posedge clk) begin
      if (rst) begin
         m_valid <= 1'b1;
         m_phase <= 0;
         m_busy  <= 1'b0;
         m_done  <= 1'b0;
         m_err   <= 1'b0;
         m_bcd   <= '0;
      end else begin
         m_done <= 1'b0;
         if (m_phase == 0) begin
            if (start) begin
               m_phase <= 1;
               m_busy  <= 1'b1;
               m_bin   <= bin;
               m_div0  <= div0;
            end
         end else if (m_phase == 17) begin
            m_phase    <= 0;
            m_busy     <= 1'b0;
            m_done     <= 1'b1;
            m_err      <= m_div0;
            m_bcd      <= m_div0 ? 20'hEEEEE : to_bcd(32'(m_bin));
            m_done_cnt <= m_done_cnt + 1;
         end else begin
            m_phase <= m_phase + 1;
         end
      end
   end

   // Per-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      if (m_valid) begin
         check("busy", 32'(busy), 32'(m_busy));
         check("done", 32'(done), 32'(m_done));
         check("err",  32'(err),  32'(m_err));
         check("bcd",  32'(bcd),  32'(m_bcd));
      end
   end

   task automatic do_reset();
      rst   = 1'b1;
      start = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while ((busy || done) && n < 40) begin
         @(negedge clk);
         n++;
      end
      check("idle_timeout", 32'(busy || done), 32'd0);
   endtask

   // One conversion with literal expectations; returns at the negedge after done was seen.
   task automatic run_conv(input string name, input logic [15:0] b, input logic d,
                           input logic [19:0] exp_bcd, input logic exp_err);
      int n;
      start = 1'b1;
      bin   = b;
      div0  = d;
      @(negedge clk);
      n = 1;
      start = 1'b0;
      bin   = 16'($urandom);
      div0  = 1'($urandom);
      while (!done && n < 40) begin
         @(negedge clk);
         n++;
      end
      check({name, "_latency"}, 32'(n), 32'd18);
      check({name, "_bcd"}, 32'(bcd), 32'(exp_bcd));
      check({name, "_err"}, 32'(err), 32'(exp_err));
      @(negedge clk);
      check({name, "_done_pulse"}, 32'(done), 32'd0);
      check({name, "_hold"}, 32'(bcd), 32'(exp_bcd));
   endtask

   initial begin
      int ndone;
      int prev;
      rst   = 1'b1;
      start = 1'b0;
      bin   = '0;
      div0  = 1'b0;
      @(negedge clk);
      do_reset();
      check("reset_busy", 32'(busy), 32'd0);
      check("reset_bcd",  32'(bcd),  32'd0);
      check("reset_err",  32'(err),  32'd0);

      run_conv("basic", 16'd1000, 1'b0, 20'h01000, 1'b0);
      run_conv("zero",  16'd0,     1'b0, 20'h00000, 1'b0);
      run_conv("max",   16'd65535, 1'b0, 20'h65535, 1'b0);
      run_conv("n9999", 16'd9999,  1'b0, 20'h09999, 1'b0);
      run_conv("div0",  16'hFFFF,  1'b1, 20'hEEEEE, 1'b1);
      run_conv("after_err", 16'd5, 1'b0, 20'h00005, 1'b0);

      // Start during busy must be ignored.
      ndone = 0;
      start = 1'b1;
      bin   = 16'd123;
      div0  = 1'b0;
      for (int cyc = 1; cyc <= 40; cyc++) begin
         @(negedge clk);
         if (done) begin
            ndone++;
            check("ignored_bcd", 32'(bcd), 32'h00123);
         end
         start = (cyc == 4);
         bin   = (cyc == 4) ? 16'd456 : 16'($urandom);
      end
      check("ignored_ndone", 32'(ndone), 32'd1);

      // Start held high: a conversion every 18 cycles.
      ndone = 0;
      prev  = -1;
      start = 1'b1;
      bin   = 16'd42;
      for (int cyc = 0; cyc < 60; cyc++) begin
         @(negedge clk);
         if (done) begin
            ndone++;
            check("b2b_bcd", 32'(bcd), 32'h00042);
            if (prev >= 0) check("b2b_period", 32'(cyc - prev), 32'd18);
            prev = cyc;
         end
      end
      check("b2b_ndone", 32'(ndone), 32'd3);
      start = 1'b0;
      wait_idle();

      // Reset at E8 of a conversion aborts it without a done pulse.
      start = 1'b1;
      bin   = 16'd777;
      for (int cyc = 1; cyc <= 7; cyc++) begin
         @(negedge clk);
         start = 1'b0;
      end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_bcd",  32'(bcd),  32'd0);
      check("abort_done", 32'(done), 32'd0);
      ndone = 0;
      repeat (20) begin
         @(negedge clk);
         if (done) ndone++;
      end
      check("abort_no_done", 32'(ndone), 32'd0);
      run_conv("after_abort", 16'd777, 1'b0, 20'h00777, 1'b0);

      // Random run: model checks every done pulse and every cycle.
      prev = m_done_cnt;
      for (int cyc = 0; cyc < 25000; cyc++) begin
         rst   = ($urandom_range(0, 2999) == 0);
         start = 1'($urandom_range(0, 1));
         bin   = 16'($urandom);
         div0  = ($urandom_range(0, 7) == 0);
         @(negedge clk);
      end
      rst   = 1'b0;
      start = 1'b0;
      repeat (20) @(negedge clk);
      check("random_conversions", 32'(m_done_cnt - prev >= 1000), 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
